// File: rtl/rob_writeback_arbiter_pkg.sv
// Shared ROB writeback types: entry layout, ROB index and the bundled FU writeback request.
package rob_writeback_arbiter_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ROB_IW    = $clog2(ROB_DEPTH);

    typedef logic [ROB_IW-1:0] rob_idx_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        done;
    } instruction_info_reg_t;

    typedef struct packed {
        rob_idx_t              idx;
        instruction_info_reg_t data;
    } wb_req_t;

endpackage

// File: rtl/rob_writeback_arbiter_rr_port_allocator.sv
// Round-robin allocator: maps pending requesters onto up to SEL_IN ports, skipping
// requesters whose index is already claimed this cycle.
module rr_port_allocator #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SEL_IN  = 2,
    parameter int unsigned IW      = 4,
    parameter int unsigned PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]         pend_v,
    input  logic [NUM_REQ-1:0][IW-1:0] pend_idx,
    input  logic [PW-1:0]              rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [SEL_IN-1:0][PW-1:0]  port_req,
    output logic [SEL_IN-1:0]          port_valid,
    output logic [PW-1:0]              next_ptr
);

    always_comb begin
        int unsigned ri;
        logic [PW-1:0] r;
        logic conflict;
        logic placed;
        grant      = '0;
        port_req   = '0;
        port_valid = '0;
        next_ptr   = rr_ptr;
        ri         = 0;
        r          = '0;
        conflict   = 1'b0;
        placed     = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            ri = 32'(rr_ptr) + k;
            if (ri >= NUM_REQ) ri = ri - NUM_REQ;
            r = PW'(ri);
            conflict = 1'b0;
            for (int unsigned p = 0; p < SEL_IN; p++) begin
                if (port_valid[p] && (pend_idx[port_req[p]] == pend_idx[r])) conflict = 1'b1;
            end
            // Ports fill in order, so the first free one is the next port to hand out.
            placed = 1'b0;
            for (int unsigned p = 0; p < SEL_IN; p++) begin
                if (!placed && !port_valid[p] && pend_v[r] && !conflict) begin
                    port_valid[p] = 1'b1;
                    port_req[p]   = r;
                    placed        = 1'b1;
                end
            end
            if (placed) begin
                grant[r] = 1'b1;
                next_ptr = (ri == NUM_REQ - 1) ? '0 : PW'(ri + 1);
            end
        end
    end

endmodule

// File: rtl/rob_writeback_arbiter.sv
// Buffers one writeback per functional unit and drains them round-robin into the
// ROB circular_queue entry-modify ports.
module rob_writeback_arbiter
    import rob_writeback_arbiter_pkg::*;
#(
    parameter type         ENTRY_TYPE = instruction_info_reg_t,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SEL_IN     = 2,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned IW        = $clog2(DEPTH),
    localparam int unsigned PW        = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0][IW-1:0]  req_idx,
    input  ENTRY_TYPE [NUM_REQ-1:0]     req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [SEL_IN-1:0][IW-1:0]   reg_select_in,
    output ENTRY_TYPE [SEL_IN-1:0]      reg_in,
    output logic [SEL_IN-1:0]           in_bitmask,
    output logic                        busy
);

    logic [NUM_REQ-1:0]         pend_v;
    logic [NUM_REQ-1:0][IW-1:0] pend_idx;
    ENTRY_TYPE [NUM_REQ-1:0]    pend_data;
    logic [PW-1:0]              rr_ptr;

    logic [NUM_REQ-1:0]         grant;
    logic [SEL_IN-1:0][PW-1:0]  port_req;
    logic [SEL_IN-1:0]          port_valid;
    logic [PW-1:0]              next_ptr;
    logic                       active;

    rr_port_allocator #(
        .NUM_REQ (NUM_REQ),
        .SEL_IN  (SEL_IN),
        .IW      (IW),
        .PW      (PW)
    ) u_alloc (
        .pend_v     (pend_v),
        .pend_idx   (pend_idx),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .port_req   (port_req),
        .port_valid (port_valid),
        .next_ptr   (next_ptr)
    );

    assign active    = ~rst & ~flush;
    assign req_ready = {NUM_REQ{active}} & (~pend_v | grant);
    assign busy      = ~rst & (|pend_v);

    always_comb begin
        in_bitmask    = '0;
        reg_select_in = '0;
        reg_in        = '0;
        for (int unsigned p = 0; p < SEL_IN; p++) begin
            if (active && port_valid[p]) begin
                in_bitmask[p]    = 1'b1;
                reg_select_in[p] = pend_idx[port_req[p]];
                reg_in[p]        = pend_data[port_req[p]];
            end
        end
    end

    // An accept on the same edge as a grant reloads the slot rather than clearing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            pend_v <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) pend_v[i] <= 1'b1;
                else if (grant[i])                pend_v[i] <= 1'b0;
            end
            if (|grant) rr_ptr <= next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                pend_idx[i]  <= req_idx[i];
                pend_data[i] <= req_data[i];
            end
        end
    end

endmodule

// File: tb/tb_rob_writeback_arbiter.sv
// Directed and randomized bench for rob_writeback_arbiter against a queue-based reference model.
module tb_rob_writeback_arbiter;
    import rob_writeback_arbiter_pkg::*;

    localparam int NREQ  = 4;
    localparam int SEL   = 2;
    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic clk = 1'b0;
    logic rst, flush;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0][IW-1:0]  req_idx;
    instruction_info_reg_t [NREQ-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic [SEL-1:0][IW-1:0]   reg_select_in;
    instruction_info_reg_t [SEL-1:0]  reg_in;
    logic [SEL-1:0]           in_bitmask;
    logic                     busy;

    rob_writeback_arbiter #(
        .ENTRY_TYPE (instruction_info_reg_t),
        .NUM_REQ    (NREQ),
        .SEL_IN     (SEL),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_idx       (req_idx),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .reg_select_in (reg_select_in),
        .reg_in        (reg_in),
        .in_bitmask    (in_bitmask),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending slots plus the requester that gets first look next cycle.
    bit                    m_v[NREQ];
    logic [IW-1:0]         m_idx[NREQ];
    instruction_info_reg_t m_data[NREQ];
    int                    m_ptr;
    int                    served[$];
    logic [NREQ-1:0]       exp_ready;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instruction_info_reg_t rand_data();
        instruction_info_reg_t d;
        d.pc     = $urandom;
        d.result = $urandom;
        d.rd     = 5'($urandom);
        d.done   = 1'($urandom);
        return d;
    endfunction

    task automatic settle();
        bit active, hit, any_v;
        logic [IW-1:0] seen[$];
        logic [SEL-1:0] e_mask;
        int r;
        @(negedge clk);
        active = !rst && !flush;
        served.delete();
        for (int k = 0; k < NREQ; k++) begin
            r = (m_ptr + k) % NREQ;
            if (served.size() < SEL && m_v[r]) begin
                hit = 0;
                foreach (seen[j]) if (seen[j] == m_idx[r]) hit = 1;
                if (!hit) begin
                    served.push_back(r);
                    seen.push_back(m_idx[r]);
                end
            end
        end
        if (!active) served.delete();
        e_mask = '0;
        for (int p = 0; p < SEL; p++) begin
            if (p < served.size()) begin
                e_mask[p] = 1'b1;
                check("model_sel", 128'(reg_select_in[p]), 128'(m_idx[served[p]]));
                check("model_data", 128'(reg_in[p]), 128'(m_data[served[p]]));
            end else begin
                check("model_sel_idle", 128'(reg_select_in[p]), 128'(0));
                check("model_data_idle", 128'(reg_in[p]), 128'(0));
            end
        end
        check("model_mask", 128'(in_bitmask), 128'(e_mask));
        any_v = 0;
        for (int i = 0; i < NREQ; i++) begin
            hit = 0;
            foreach (served[j]) if (served[j] == i) hit = 1;
            exp_ready[i] = active && (!m_v[i] || hit);
            if (m_v[i]) any_v = 1;
        end
        check("model_ready", 128'(req_ready), 128'(exp_ready));
        check("model_busy", 128'(busy), 128'(!rst && any_v));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREQ; i++) m_v[i] = 0;
            m_ptr = 0;
        end else if (flush) begin
            for (int i = 0; i < NREQ; i++) m_v[i] = 0;
        end else begin
            foreach (served[j]) m_v[served[j]] = 0;
            if (served.size() > 0) m_ptr = (served[served.size()-1] + 1) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && exp_ready[i]) begin
                    m_v[i]    = 1;
                    m_idx[i]  = req_idx[i];
                    m_data[i] = req_data[i];
                end
            end
        end
        #1;
    endtask

    initial begin
        instruction_info_reg_t d0, d1, d9;
        int last0;
        int age[NREQ];
        bit s[NREQ];

        rst = 1'b1; flush = 1'b0; req_valid = '0; req_idx = '0; req_data = '0;
        for (int i = 0; i < NREQ; i++) m_v[i] = 0;
        m_ptr = 0;

        // Reset state
        settle();
        check("reset_mask", 128'(in_bitmask), 128'(0));
        check("reset_ready", 128'(req_ready), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        tick();
        rst = 1'b0;
        settle(); tick();

        // Single request
        d0 = rand_data();
        req_valid = 4'b0010; req_idx[1] = 4'd5; req_data[1] = d0;
        settle(); tick();
        req_valid = '0;
        settle();
        check("single_mask", 128'(in_bitmask), 128'(2'b01));
        check("single_sel", 128'(reg_select_in[0]), 128'(5));
        check("single_data", 128'(reg_in[0]), 128'(d0));
        tick();
        settle();
        check("single_busy_clear", 128'(busy), 128'(0));
        tick();

        // Full load from pointer 0
        rst = 1'b1; settle(); tick();
        rst = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_idx[i] = IW'(i + 1); req_data[i] = rand_data();
        end
        settle(); tick();
        req_valid = '0;
        settle();
        check("full_a_mask", 128'(in_bitmask), 128'(2'b11));
        check("full_a_sel0", 128'(reg_select_in[0]), 128'(1));
        check("full_a_sel1", 128'(reg_select_in[1]), 128'(2));
        tick(); settle();
        check("full_b_sel0", 128'(reg_select_in[0]), 128'(3));
        check("full_b_sel1", 128'(reg_select_in[1]), 128'(4));
        tick(); settle();
        check("full_drained", 128'(in_bitmask), 128'(0));
        tick();

        // Index conflict
        d0 = rand_data(); d1 = rand_data();
        req_valid = 4'b0011; req_idx[0] = 4'd7; req_idx[1] = 4'd7;
        req_data[0] = d0; req_data[1] = d1;
        settle(); tick();
        req_valid = '0;
        settle();
        check("conflict_c1_mask", 128'(in_bitmask), 128'(2'b01));
        check("conflict_c1_data", 128'(reg_in[0]), 128'(d0));
        check("conflict_c1_ready1", 128'(req_ready[1]), 128'(0));
        tick(); settle();
        check("conflict_c2_mask", 128'(in_bitmask), 128'(2'b01));
        check("conflict_c2_sel", 128'(reg_select_in[0]), 128'(7));
        check("conflict_c2_data", 128'(reg_in[0]), 128'(d1));
        tick(); settle(); tick();

        // Grant plus reload on the same edge
        req_valid = 4'b0100; req_idx[2] = 4'd3; req_data[2] = rand_data();
        settle(); tick();
        d9 = rand_data();
        req_idx[2] = 4'd9; req_data[2] = d9;
        settle();
        check("reload_ready2", 128'(req_ready[2]), 128'(1));
        check("reload_old_sel", 128'(reg_select_in[0]), 128'(3));
        tick();
        req_valid = '0;
        settle();
        check("reload_new_mask", 128'(in_bitmask), 128'(2'b01));
        check("reload_new_sel", 128'(reg_select_in[0]), 128'(9));
        check("reload_new_data", 128'(reg_in[0]), 128'(d9));
        tick(); settle();
        check("reload_no_dup", 128'(in_bitmask), 128'(0));
        tick();

        // Fairness with every requester re-asserting each cycle
        last0 = -10;
        for (int i = 0; i < NREQ; i++) begin
            age[i] = 0; req_idx[i] = IW'(i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_data[i] = rand_data(); s[i] = 0;
            end
            settle();
            for (int p = 0; p < SEL; p++)
                if (in_bitmask[p] && reg_select_in[p] < NREQ) s[reg_select_in[p]] = 1;
            if (s[0]) begin
                if (last0 >= 0) check("fair_req0_gap", 128'(c - last0 >= 2), 128'(1));
                last0 = c;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (s[i]) age[i] = 0;
                else if (m_v[i]) age[i]++;
                check("fair_wait_bound", 128'(age[i] <= 1), 128'(1));
            end
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin settle(); tick(); end

        // Flush with three pending slots and a request presented during flush
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            req_idx[i] = IW'(i + 1); req_data[i] = rand_data();
        end
        settle(); tick();
        flush = 1'b1; req_valid = 4'b1000; req_idx[3] = 4'd4; req_data[3] = rand_data();
        settle();
        check("flush_mask", 128'(in_bitmask), 128'(0));
        check("flush_ready", 128'(req_ready), 128'(0));
        tick();
        flush = 1'b0; req_valid = '0;
        settle();
        check("flush_busy", 128'(busy), 128'(0));
        check("flush_ready_after", 128'(req_ready), 128'(4'b1111));
        tick();

        // Reset in the middle of operation
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            req_idx[i] = IW'(i + 5); req_data[i] = rand_data();
        end
        settle(); tick();
        req_valid = '0;
        settle(); tick();
        rst = 1'b1;
        settle();
        check("rst_mid_mask", 128'(in_bitmask), 128'(0));
        check("rst_mid_ready", 128'(req_ready), 128'(0));
        check("rst_mid_busy", 128'(busy), 128'(0));
        tick();
        rst = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_idx[i] = IW'(i + 10); req_data[i] = rand_data();
        end
        settle();
        check("rst_after_ready", 128'(req_ready), 128'(4'b1111));
        check("rst_after_busy", 128'(busy), 128'(0));
        tick();
        req_valid = '0;
        settle();
        check("rst_ptr0_sel0", 128'(reg_select_in[0]), 128'(10));
        check("rst_ptr0_sel1", 128'(reg_select_in[1]), 128'(11));
        tick(); settle();
        check("rst_ptr0_sel2", 128'(reg_select_in[0]), 128'(12));
        check("rst_ptr0_sel3", 128'(reg_select_in[1]), 128'(13));
        tick();

        // Randomized traffic with conflicts, flushes and resets
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_idx[i]  = IW'($urandom_range(0, 5));
                req_data[i] = rand_data();
            end
            settle(); tick();
        end
        rst = 1'b0; flush = 1'b0; req_valid = '0;
        for (int c = 0; c < 4; c++) begin settle(); tick(); end
        check("final_idle", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_writeback_arbiter.md
Name: rob_writeback_arbiter

Overview:
- Shares the SEL_IN entry-modify ports (reg_select_in / reg_in / in_bitmask) of the ROB circular_queue among NUM_REQ functional-unit writeback requesters.
- Each requester owns a one-deep pending slot, so an FU can fire and forget.
- A round-robin allocator drains up to SEL_IN slots per cycle into the queue's modify ports.
- Sits between the FU writeback stage and the ROB instance of circular_queue.

Parameters:
- ENTRY_TYPE, instruction_info_reg_t, entry type written into the ROB (matches the queue's QUEUE_TYPE).
- NUM_REQ, 4, number of writeback requesters (>=2; not required to be a power of two).
- SEL_IN, 2, number of queue modify ports driven (1..NUM_REQ).
- DEPTH, 16, ROB depth; index width IW = $clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush (mispredict); discards all pending writebacks.
- req_valid  in  [NUM_REQ]  requester i has a writeback.
- req_idx  in  IW x NUM_REQ  ROB index to update.
- req_data  in  ENTRY_TYPE x NUM_REQ  updated entry contents.
- req_ready  out  [NUM_REQ]  slot i can accept this cycle.
- reg_select_in  out  IW x SEL_IN  to queue reg_select_in.
- reg_in  out  ENTRY_TYPE x SEL_IN  to queue reg_in.
- in_bitmask  out  [SEL_IN]  to queue in_bitmask.
- busy  out  1  any slot pending.

Behaviour:
- State:
  - pend_v[i], pend_idx[i], pend_data[i] per requester.
  - rr_ptr, $clog2(NUM_REQ) bits, range 0..NUM_REQ-1.
- Reset (rst=1 at posedge):
  - pend_v all 0 and rr_ptr=0.
  - While rst is high: req_ready all 0, in_bitmask 0, busy 0.
- Accept:
  - Transfer on posedge when req_valid[i] & req_ready[i]; loads pend_* for slot i.
  - req_ready[i] = ~rst & ~flush & (~pend_v[i] | grant[i]).
  - req_ready[i] must not depend on req_valid.
- Grant (combinational from flops only):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - Each pend_v requester takes the next free port (0, 1, ...) until SEL_IN ports are used.
  - Skip a requester whose pend_idx equals an idx already granted this cycle; it stays pending.
  - This guarantees distinct reg_select_in among set bits, so there is never a write-order race inside the queue.
- Port outputs:
  - Granted port p: in_bitmask[p]=1, reg_select_in[p]=pend_idx, reg_in[p]=pend_data.
  - Unused port: bitmask 0, select 0, data '0 (never X).
- Latency:
  - A request accepted at edge t drives the ports in cycle t+1 at the earliest.
  - The queue writes at edge t+2.
- Slot update at posedge:
  - Granted slot clears, unless it is reloaded in the same edge (grant + accept: the new request overwrites).
- rr_ptr update:
  - If any grant, rr_ptr <= (last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Wrap uses compare-and-reset, not bit truncation.
- Fairness: a pending slot is granted within ceil(NUM_REQ/SEL_IN) cycles, barring index conflicts.
- Flush:
  - In the flush cycle: in_bitmask=0, req_ready=0, rr_ptr held.
  - Requests presented during flush are dropped.
  - All pend_v clear at the edge.
- rst has priority over flush.
- busy = OR(pend_v).

Decomposition:
- Shared package (rv32i_types):
  - rob_idx_t = logic [IW-1:0].
  - wb_req_t struct {idx, data}, so FU ports bundle cleanly.
- Sub-module rr_port_allocator (combinational): inputs pend_v, pend_idx, rr_ptr; outputs grant vector, per-port requester id, port valid, next_ptr.
- Reusable later for CDB and issue arbitration.

Test Plan:
- Single request: rst released, req_valid[1]=1, idx=5 at t -> cycle t+1 in_bitmask=01, reg_select_in[0]=5, reg_in[0]=req_data; busy=0 at t+2.
- Full load, ptr 0: all 4 slots pending with idx 1,2,3,4 -> cycle A ports serve req0/req1 (idx 1,2), rr_ptr=2; cycle B req2/req3 (idx 3,4), rr_ptr=0; then bitmask 00.
- Fairness: req0 re-asserts every cycle while req1..3 pending -> req0 served at most once every 2 cycles, and every other requester is granted within 2 cycles of pending.
- Index conflict: req0 and req1 both idx 7, rr_ptr=0 -> cycle 1 only port0=req0 with bitmask 01; cycle 2 port0=req1 idx 7; req1 req_ready stays 0 in cycle 1.
- Grant+reload: req2 pending and granted while req_valid[2]=1 with idx 9 -> req_ready[2]=1, and idx 9 appears on a port the next cycle with no lost or duplicated write.
- Flush/reset: 3 slots pending, flush=1 -> that cycle bitmask 00 and ready all 0; next cycle busy=0 and ready all 1. Repeat with rst mid-operation -> same, plus rr_ptr=0.
